push_button_debouncer: RTL and testbench

Conditions the four raw board push buttons before they reach the push-button PIO read port. Each button is synchronised into `clk`, debounced with a per-button stability counter and inverted to active-high. The block emits a clean level vector (wired to the PIO `in_port`) plus one-cycle press pulses with hold-to-repeat, used by the alarm-setting logic.

---
 rtl/push_button_debouncer.sv | 73 +++++++
 tb/tb_push_button_debouncer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/push_button_debouncer.sv
// push_button_debouncer: synchronise, debounce and invert raw buttons; emit level plus press/release/repeat strobes.
module push_button_debouncer #(
  parameter int unsigned WIDTH = 4,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_buttons,
  output logic [WIDTH-1:0] btn_state,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned MAXR = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW = MAXR > 1 ? $clog2(MAXR + 1) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [1:0] RELEASED = 2'd0;
  localparam logic [1:0] HELD = 2'd1;
  localparam logic [1:0] REPEATING = 2'd2;
  for (genvar i = 0; i < WIDTH; i++) begin : g_btn
    logic s1, s2, st, pp, rp;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt;
    logic [1:0] fsm;
    logic mism, accept, expire;
    assign mism = s2 != st;
    assign accept = mism && dcnt == D_LAST;
    // a zero repeat delay keeps HELD forever; only a release leaves it
    assign expire = fsm == HELD ? REPEAT_DELAY != 0 && rcnt == RD_LAST
                                : fsm == REPEATING && rcnt == RP_LAST;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        st <= 1'b0;
        dcnt <= '0;
        rcnt <= '0;
        fsm <= RELEASED;
        pp <= 1'b0;
        rp <= 1'b0;
      end else begin
        s1 <= raw_buttons[i] ^ ACTIVE_LOW;
        s2 <= s1;
        dcnt <= mism && !accept ? dcnt + 1'b1 : '0;
        if (accept) st <= s2;
        pp <= 1'b0;
        rp <= 1'b0;
        if (fsm == RELEASED) begin
          rcnt <= '0;
          if (accept) begin
            pp <= 1'b1;
            fsm <= HELD;
          end
        end else if (accept) begin
          rp <= 1'b1;
          rcnt <= '0;
          fsm <= RELEASED;
        end else if (expire) begin
          pp <= 1'b1;
          rcnt <= '0;
          fsm <= REPEATING;
        end else rcnt <= rcnt + 1'b1;
      end
    assign btn_state[i] = st;
    assign press_pulse[i] = pp;
    assign release_pulse[i] = rp;
  end
endmodule

// File: tb/tb_push_button_debouncer.sv
// tb_push_button_debouncer: directed stimulus checked every cycle against a window/arithmetic model.
module tb_push_button_debouncer;
  localparam int W = 4;
  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam bit AL = 1'b1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] raw_buttons = 4'hF;
  logic [W-1:0] btn_state, press_pulse, release_pulse;
  int tests = 0;
  int failed = 0;
  bit run = 1'b0;

  push_button_debouncer #(
    .WIDTH(W), .ACTIVE_LOW(AL), .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .raw_buttons(raw_buttons),
    .btn_state(btn_state), .press_pulse(press_pulse), .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: a level is accepted once the DC samples taken 2..DC+1 edges ago
  // all disagree with the current level; repeats follow from the press time.
  logic [15:0] hist [W];
  logic [W-1:0] exp_state = '0, exp_pp = '0, exp_rp = '0;
  int tp [W];
  int edge_n = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < W; b++) hist[b] = '0;
      exp_state = '0;
      exp_pp = '0;
      exp_rp = '0;
    end else begin
      edge_n++;
      exp_pp = '0;
      exp_rp = '0;
      for (int b = 0; b < W; b++) begin
        logic all_p, all_r;
        int d;
        hist[b] = {hist[b][14:0], raw_buttons[b] ^ AL};
        all_p = 1'b1;
        all_r = 1'b1;
        for (int k = 2; k <= DC + 1; k++) begin
          all_p &= hist[b][k];
          all_r &= ~hist[b][k];
        end
        if (!exp_state[b] && all_p) begin
          exp_state[b] = 1'b1;
          exp_pp[b] = 1'b1;
          tp[b] = edge_n;
        end else if (exp_state[b] && all_r) begin
          exp_state[b] = 1'b0;
          exp_rp[b] = 1'b1;
        end else if (exp_state[b]) begin
          d = edge_n - tp[b];
          exp_pp[b] = d == RD || (d > RD && (d - RD) % RP == 0);
        end
      end
    end
  end

  always @(negedge clk)
    if (run) begin
      chk("model_btn_state", 32'(btn_state), 32'(exp_state));
      chk("model_press_pulse", 32'(press_pulse), 32'(exp_pp));
      chk("model_release_pulse", 32'(release_pulse), 32'(exp_rp));
    end

  initial begin
    logic [W-1:0] acc;
    logic [31:0] mask;
    cyc(2);
    chk("reset_btn_state", 32'(btn_state), 0);
    chk("reset_press", 32'(press_pulse), 0);
    chk("reset_release", 32'(release_pulse), 0);
    cyc(1);
    reset = 1'b0;
    run = 1'b1;
    acc = '0;
    repeat (50) begin
      cyc(1);
      acc |= btn_state | press_pulse | release_pulse;
    end
    chk("idle_quiet", 32'(acc), 0);
    // clean press on bit 0, then release timed onto the second repeat expiry
    raw_buttons[0] = 1'b0;
    cyc(5);
    chk("press_edge4_state", 32'(btn_state[0]), 0);
    cyc(1);
    chk("press_edge5_state", 32'(btn_state[0]), 1);
    chk("press_edge5_pulse", 32'(press_pulse[0]), 1);
    cyc(1);
    chk("press_edge6_pulse", 32'(press_pulse[0]), 0);
    cyc(9);
    chk("first_repeat", 32'(press_pulse[0]), 1);
    raw_buttons[0] = 1'b1;
    cyc(5);
    chk("release_early", 32'(release_pulse[0]), 0);
    cyc(1);
    chk("release_on_expiry_rp", 32'(release_pulse[0]), 1);
    chk("release_on_expiry_pp", 32'(press_pulse[0]), 0);
    chk("release_on_expiry_state", 32'(btn_state[0]), 0);
    cyc(5);
    // bounce on bit 1
    acc = '0;
    for (int t = 0; t < 4; t++) begin
      raw_buttons[1] = t[0];
      repeat (2) begin
        cyc(1);
        acc |= btn_state | press_pulse | release_pulse;
      end
    end
    raw_buttons[1] = 1'b1;
    repeat (10) begin
      cyc(1);
      acc |= btn_state | press_pulse | release_pulse;
    end
    chk("bounce_quiet", 32'(acc), 0);
    // long hold on bit 2
    raw_buttons[2] = 1'b0;
    cyc(5);
    mask = '0;
    for (int k = 0; k <= 30; k++) begin
      cyc(1);
      mask[k] = press_pulse[2];
    end
    chk("hold_repeat_mask", mask, 32'h12492401);
    raw_buttons[2] = 1'b1;
    cyc(5);
    chk("hold_release_early", 32'(release_pulse[2]), 0);
    cyc(1);
    chk("hold_release", 32'(release_pulse[2]), 1);
    acc = '0;
    repeat (20) begin
      cyc(1);
      acc |= press_pulse;
    end
    chk("hold_repeats_stop", 32'(acc), 0);
    // simultaneous press and release on bits 0 and 1
    raw_buttons = 4'hC;
    cyc(6);
    chk("simul_press", 32'(press_pulse), 32'h3);
    chk("simul_state", 32'(btn_state), 32'h3);
    raw_buttons = 4'hF;
    cyc(6);
    chk("simul_release", 32'(release_pulse), 32'h3);
    cyc(5);
    // reset during hold of bit 3
    raw_buttons = 4'h7;
    cyc(20);
    chk("pre_reset_state", 32'(btn_state), 32'h8);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_state", 32'(btn_state), 0);
    chk("async_reset_press", 32'(press_pulse), 0);
    chk("async_reset_release", 32'(release_pulse), 0);
    cyc(2);
    @(posedge clk);
    #2 reset = 1'b0;
    cyc(6);
    chk("rearm_edge4", 32'(press_pulse[3]), 0);
    cyc(1);
    chk("rearm_edge5", 32'(press_pulse[3]), 1);
    raw_buttons = 4'hF;
    cyc(10);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
